// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundle of the two requester ports and the sram_controller command port.
//   m0_*/m1_*   : requester request, address, write enable, write data, ack, read-valid
//   m_rdata     : shared read data returned to the requesters
//   s_*         : command to the controller (req/addr/write_enable/write_data), ready and read data back
//   slave modport is the arbiter's view; master modport is the surrounding system's view.
interface sram_arbiter_if #(
    parameter int ADDR_BITS = 20,
    parameter int DATA_BITS = 16
);
    logic                 m0_req, m1_req;
    logic [ADDR_BITS-1:0] m0_addr, m1_addr;
    logic                 m0_write_enable, m1_write_enable;
    logic [DATA_BITS-1:0] m0_write_data, m1_write_data;
    logic                 m0_ack, m1_ack;
    logic                 m0_rvalid, m1_rvalid;
    logic [DATA_BITS-1:0] m_rdata;
    logic                 s_req;
    logic [ADDR_BITS-1:0] s_addr;
    logic                 s_write_enable;
    logic [DATA_BITS-1:0] s_write_data;
    logic                 s_ready;
    logic [DATA_BITS-1:0] s_rdata;

    modport slave (
        input  m0_req, m1_req, m0_addr, m1_addr, m0_write_enable, m1_write_enable,
               m0_write_data, m1_write_data, s_ready, s_rdata,
        output m0_ack, m1_ack, m0_rvalid, m1_rvalid, m_rdata,
               s_req, s_addr, s_write_enable, s_write_data
    );

    modport master (
        output m0_req, m1_req, m0_addr, m1_addr, m0_write_enable, m1_write_enable,
               m0_write_data, m1_write_data, s_ready, s_rdata,
        input  m0_ack, m1_ack, m0_rvalid, m1_rvalid, m_rdata,
               s_req, s_addr, s_write_enable, s_write_data
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter with burst limit in front of an sram_controller.
//   clk   : sole clock, rising edge
//   reset : synchronous active-high reset
//   bus   : sram_arbiter_if.slave carrying both requester ports and the controller command port
module sram_arbiter #(
    parameter int ADDR_BITS    = 20,
    parameter int DATA_BITS    = 16,
    parameter int READ_LATENCY = 2,
    parameter int MAX_BURST    = 8
) (
    input logic            clk,
    input logic            reset,
    sram_arbiter_if.slave  bus
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t                  state, state_next;
    logic                    last_grant;
    logic [CW-1:0]           cnt, cnt_inc;
    logic                    issue0, issue1, burst_done, rd_issue;
    logic [READ_LATENCY-1:0] pv, pid;

    assign issue0     = state == GRANT0 && bus.m0_req && bus.s_ready;
    assign issue1     = state == GRANT1 && bus.m1_req && bus.s_ready;
    assign rd_issue   = (issue0 && !bus.m0_write_enable) || (issue1 && !bus.m1_write_enable);
    // saturating so a long solo burst cannot wrap and delay the other port's turn
    assign cnt_inc    = cnt == CW'(MAX_BURST) ? cnt : cnt + 1'b1;
    assign burst_done = cnt_inc == CW'(MAX_BURST);

    assign bus.s_req          = state == GRANT0 ? bus.m0_req : state == GRANT1 ? bus.m1_req : 1'b0;
    assign bus.s_addr         = ADDR_BITS'(state == GRANT1 ? bus.m1_addr : bus.m0_addr);
    assign bus.s_write_enable = state == GRANT1 ? bus.m1_write_enable : bus.m0_write_enable;
    assign bus.s_write_data   = DATA_BITS'(state == GRANT1 ? bus.m1_write_data : bus.m0_write_data);
    assign bus.m0_ack         = issue0;
    assign bus.m1_ack         = issue1;
    assign bus.m0_rvalid      = pv[READ_LATENCY-1] && !pid[READ_LATENCY-1];
    assign bus.m1_rvalid      = pv[READ_LATENCY-1] && pid[READ_LATENCY-1];
    assign bus.m_rdata        = DATA_BITS'(bus.s_rdata);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (bus.m0_req && bus.m1_req) ? (last_grant ? GRANT0 : GRANT1) :
                                  bus.m0_req ? GRANT0 : bus.m1_req ? GRANT1 : IDLE;
            GRANT0:  state_next = !(bus.m0_req || bus.m1_req) ? IDLE :
                                  (bus.m1_req && (!bus.m0_req || (issue0 && burst_done))) ? GRANT1 : GRANT0;
            GRANT1:  state_next = !(bus.m0_req || bus.m1_req) ? IDLE :
                                  (bus.m0_req && (!bus.m1_req || (issue1 && burst_done))) ? GRANT0 : GRANT1;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            pv         <= '0;
            pid        <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                cnt <= '0;
            else if (issue0 || issue1)
                cnt <= cnt_inc;
            if (issue0)
                last_grant <= 1'b0;
            else if (issue1)
                last_grant <= 1'b1;
            // read-return tracker: one slot per cycle, valid only for issued reads
            pv[0]  <= rd_issue;
            pid[0] <= issue1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv[i]  <= pv[i-1];
                pid[i] <= pid[i-1];
            end
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed tests of sram_arbiter against a small SRAM controller model.
module tb_sram_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    sram_arbiter_if #(.ADDR_BITS(20), .DATA_BITS(16)) bus();

    sram_arbiter #(.ADDR_BITS(20), .DATA_BITS(16), .READ_LATENCY(2), .MAX_BURST(8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // controller model: unwritten locations read as {addr[7:0], ~addr[7:0]}, two-cycle read latency
    logic [15:0]  mem [0:255];
    logic [255:0] wr;
    logic [15:0]  rp0, rp1;
    logic [7:0]   ma;
    assign ma          = bus.s_addr[7:0];
    assign bus.s_rdata = rp1;

    always @(posedge clk) begin
        if (reset)
            wr <= '0;
        else if (bus.s_req && bus.s_ready && bus.s_write_enable) begin
            mem[ma] <= bus.s_write_data;
            wr[ma]  <= 1'b1;
        end
        rp0 <= (bus.s_req && bus.s_ready && !bus.s_write_enable) ? (wr[ma] && !reset ? mem[ma] : {ma, ~ma}) : 16'hDEAD;
        rp1 <= rp0;
    end

    function automatic logic burst_ack(int c, int port);
        return c >= 1 && ((c - 1) / 8) % 2 == port;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m0_req = 0; bus.m1_req = 0;
        bus.m0_addr = '0; bus.m1_addr = '0;
        bus.m0_write_enable = 0; bus.m1_write_enable = 0;
        bus.m0_write_data = '0; bus.m1_write_data = '0;
        bus.s_ready = 1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.m0_req = 1;
        bus.m1_req = 1;
        reset = 1;
        tick();
        tick();
        vectors++;
        if (bus.s_req !== 1'b0) begin miscompares++; $display("FAIL reset_s_req got %b want 0", bus.s_req); end
        vectors++;
        if ({bus.m0_ack, bus.m1_ack} !== 2'b00) begin miscompares++; $display("FAIL reset_ack got %b want 00", {bus.m0_ack, bus.m1_ack}); end
        vectors++;
        if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b00) begin miscompares++; $display("FAIL reset_rvalid got %b want 00", {bus.m0_rvalid, bus.m1_rvalid}); end
        do_reset();
        vectors++;
        if (bus.s_req !== 1'b0) begin miscompares++; $display("FAIL post_reset_s_req got %b want 0", bus.s_req); end
    endtask

    task automatic test_single_read();
        do_reset();
        bus.m0_req = 1;
        bus.m0_addr = 20'h00010;
        #1;
        vectors++;
        if (bus.m0_ack !== 1'b0) begin miscompares++; $display("FAIL single_idle_ack got %b want 0", bus.m0_ack); end
        tick();
        vectors++;
        if ({bus.m0_ack, bus.s_req, bus.s_addr} !== {1'b1, 1'b1, 20'h00010}) begin
            miscompares++; $display("FAIL single_ack got ack=%b req=%b addr=%h want 1 1 00010", bus.m0_ack, bus.s_req, bus.s_addr);
        end
        tick();
        bus.m0_req = 0;
        #1;
        vectors++;
        if ({bus.m0_rvalid, bus.m1_rvalid, bus.m0_ack} !== 3'b000) begin
            miscompares++; $display("FAIL single_t1 got rv0=%b rv1=%b ack0=%b want 000", bus.m0_rvalid, bus.m1_rvalid, bus.m0_ack);
        end
        tick();
        vectors++;
        if ({bus.m0_rvalid, bus.m1_rvalid, bus.m1_ack} !== 3'b100) begin
            miscompares++; $display("FAIL single_t2_valid got rv0=%b rv1=%b ack1=%b want 100", bus.m0_rvalid, bus.m1_rvalid, bus.m1_ack);
        end
        vectors++;
        if (bus.m_rdata !== 16'h10EF) begin miscompares++; $display("FAIL single_t2_data got %h want 10ef", bus.m_rdata); end
        tick();
        vectors++;
        if (bus.m0_rvalid !== 1'b0) begin miscompares++; $display("FAIL single_t3_rvalid got %b want 0", bus.m0_rvalid); end
    endtask

    task automatic test_burst();
        do_reset();
        bus.m0_req = 1; bus.m0_addr = 20'h00020;
        bus.m1_req = 1; bus.m1_addr = 20'h00021;
        for (int c = 0; c < 35; c++) begin
            #1;
            vectors++;
            if ({bus.m0_ack, bus.m1_ack} !== {burst_ack(c, 0), burst_ack(c, 1)}) begin
                miscompares++; $display("FAIL burst_ack c=%0d got %b%b want %b%b", c, bus.m0_ack, bus.m1_ack, burst_ack(c, 0), burst_ack(c, 1));
            end
            vectors++;
            if ({bus.m0_rvalid, bus.m1_rvalid} !== {burst_ack(c - 2, 0), burst_ack(c - 2, 1)}) begin
                miscompares++; $display("FAIL burst_rvalid c=%0d got %b%b want %b%b", c, bus.m0_rvalid, bus.m1_rvalid, burst_ack(c - 2, 0), burst_ack(c - 2, 1));
            end
            if (burst_ack(c - 2, 0) || burst_ack(c - 2, 1)) begin
                vectors++;
                if (bus.m_rdata !== (burst_ack(c - 2, 0) ? 16'h20DF : 16'h21DE)) begin
                    miscompares++; $display("FAIL burst_data c=%0d got %h", c, bus.m_rdata);
                end
            end
            @(posedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_write_then_read();
        do_reset();
        bus.m0_req = 1; bus.m0_addr = 20'h00003; bus.m0_write_enable = 1; bus.m0_write_data = 16'hA5A5;
        tick();
        vectors++;
        if ({bus.m0_ack, bus.s_write_enable, bus.s_write_data} !== {1'b1, 1'b1, 16'hA5A5}) begin
            miscompares++; $display("FAIL wr_ack got ack=%b we=%b wd=%h want 1 1 a5a5", bus.m0_ack, bus.s_write_enable, bus.s_write_data);
        end
        tick();
        bus.m0_req = 0; bus.m0_write_enable = 0;
        bus.m1_req = 1; bus.m1_addr = 20'h00003;
        #1;
        vectors++;
        if ({bus.m0_ack, bus.m1_ack} !== 2'b00) begin miscompares++; $display("FAIL wr_switch_gap got %b want 00", {bus.m0_ack, bus.m1_ack}); end
        tick();
        vectors++;
        if ({bus.m1_ack, bus.m0_rvalid} !== 2'b10) begin
            miscompares++; $display("FAIL rd_ack got ack1=%b rv0=%b want 1 0", bus.m1_ack, bus.m0_rvalid);
        end
        tick();
        bus.m1_req = 0;
        #1;
        vectors++;
        if (bus.m1_rvalid !== 1'b0) begin miscompares++; $display("FAIL rd_early got %b want 0", bus.m1_rvalid); end
        tick();
        vectors++;
        if ({bus.m1_rvalid, bus.m0_rvalid, bus.m_rdata} !== {2'b10, 16'hA5A5}) begin
            miscompares++; $display("FAIL rd_return got rv1=%b rv0=%b data=%h want 1 0 a5a5", bus.m1_rvalid, bus.m0_rvalid, bus.m_rdata);
        end
    endtask

    task automatic test_stall();
        do_reset();
        bus.m1_req = 1; bus.m1_addr = 20'h00055; bus.s_ready = 0;
        #1;
        vectors++;
        if (bus.s_req !== 1'b0) begin miscompares++; $display("FAIL stall_idle_s_req got %b want 0", bus.s_req); end
        for (int c = 1; c <= 5; c++) begin
            tick();
            vectors++;
            if ({bus.m1_ack, bus.m0_ack, bus.s_req, bus.s_addr} !== {3'b001, 20'h00055}) begin
                miscompares++; $display("FAIL stall c=%0d got ack1=%b ack0=%b req=%b addr=%h want 0 0 1 00055", c, bus.m1_ack, bus.m0_ack, bus.s_req, bus.s_addr);
            end
        end
        tick();
        bus.s_ready = 1;
        #1;
        vectors++;
        if (bus.m1_ack !== 1'b1) begin miscompares++; $display("FAIL stall_release got %b want 1", bus.m1_ack); end
        tick();
        clear_inputs();
    endtask

    task automatic test_interleave();
        logic [8:0] q0, q1, a0, a1, v0, v1;
        logic [15:0] d;
        q0 = 9'b000110011; q1 = 9'b000001100;
        a0 = 9'b000100010; a1 = 9'b000001000;
        v0 = 9'b010001000; v1 = 9'b000100000;
        do_reset();
        bus.m1_addr = 20'h00041;
        for (int c = 0; c < 9; c++) begin
            bus.m0_req  = q0[c];
            bus.m1_req  = q1[c];
            bus.m0_addr = c < 4 ? 20'h00040 : 20'h00042;
            #1;
            vectors++;
            if ({bus.m0_ack, bus.m1_ack, bus.m0_rvalid, bus.m1_rvalid} !== {a0[c], a1[c], v0[c], v1[c]}) begin
                miscompares++; $display("FAIL interleave c=%0d got ack=%b%b rv=%b%b want %b%b %b%b", c, bus.m0_ack, bus.m1_ack,
                    bus.m0_rvalid, bus.m1_rvalid, a0[c], a1[c], v0[c], v1[c]);
            end
            if (v0[c] || v1[c]) begin
                d = c == 3 ? 16'h40BF : c == 5 ? 16'h41BE : 16'h42BD;
                vectors++;
                if (bus.m_rdata !== d) begin miscompares++; $display("FAIL interleave_data c=%0d got %h want %h", c, bus.m_rdata, d); end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_flush();
        do_reset();
        bus.m0_req = 1; bus.m0_addr = 20'h00010;
        tick();
        vectors++;
        if (bus.m0_ack !== 1'b1) begin miscompares++; $display("FAIL flush_ack got %b want 1", bus.m0_ack); end
        tick();
        bus.m0_req = 0;
        reset = 1;
        tick();
        reset = 0;
        bus.m1_req = 1;
        #1;
        vectors++;
        if ({bus.s_req, bus.m1_ack} !== 2'b00) begin
            miscompares++; $display("FAIL flush_idle got req=%b ack1=%b want 0 0", bus.s_req, bus.m1_ack);
        end
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b00) begin
                miscompares++; $display("FAIL flush_rvalid c=%0d got %b%b want 00", c, bus.m0_rvalid, bus.m1_rvalid);
            end
            bus.m1_req = 0;
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        reset = 1;
        test_reset();
        test_single_read();
        test_burst();
        test_write_then_read();
        test_stall();
        test_interleave();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 20, SRAM address width.
REQ-002 SHALL have parameter DATA_BITS, default 16, SRAM data width.
REQ-003 SHALL have parameter READ_LATENCY, default 2, cycles from command issue to valid s_rdata.
REQ-004 SHALL have parameter MAX_BURST, default 8, maximum consecutive issues to one port while the other port waits.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have ports m0_req/m1_req  input  1  port N requests a transaction.
REQ-008 SHALL have ports m0_addr/m1_addr  input  ADDR_BITS  port N address.
REQ-009 SHALL have ports m0_write_enable/m1_write_enable  input  1  1 = write, 0 = read.
REQ-010 SHALL have ports m0_write_data/m1_write_data  input  DATA_BITS  port N write data.
REQ-011 SHALL have ports m0_ack/m1_ack  output  1  one-cycle pulse; port N command issued this cycle.
REQ-012 SHALL have ports m0_rvalid/m1_rvalid  output  1  read data for port N valid this cycle.
REQ-013 SHALL have port m_rdata  output  DATA_BITS  read data, shared by both ports, qualified by mN_rvalid.
REQ-014 SHALL have ports s_req, s_addr, s_write_enable, s_write_data  output  1/ADDR_BITS/1/DATA_BITS  command to sram_controller.
REQ-015 SHALL have port s_ready  input  1  controller accepts a command when s_req && s_ready.
REQ-016 SHALL have port s_rdata  input  DATA_BITS  controller read data.

Function
REQ-017 SHALL implement FSM states IDLE, GRANT0, GRANT1.
REQ-018 IDLE: if exactly one port requests, go to its GRANTn; if both request, grant the port that is not last_grant; otherwise stay in IDLE.
REQ-019 In GRANTn, s_req SHALL equal mn_req, and s_addr/s_write_enable/s_write_data SHALL be driven combinationally from port n; in IDLE, s_req = 0.
REQ-020 An issue SHALL occur when GRANTn && mn_req && s_ready; in that cycle mn_ack = 1, and the other port's ack = 0.
REQ-021 A burst counter SHALL reset to 0 on entering GRANTn and SHALL increment on each issue.
REQ-022 GRANTn SHALL go to GRANT(other) when the other port requests and either mn_req = 0 or the counter reaches MAX_BURST after an issue.
REQ-023 GRANTn SHALL go to IDLE when neither port requests.
REQ-024 GRANTn SHALL otherwise stay in GRANTn.
REQ-025 last_grant SHALL update to n on every issue by port n.
REQ-026 A requester SHALL hold its addr, write_enable and write_data stable from raising req until its ack; the arbiter does not register them.
REQ-027 Each issued read SHALL push {valid = 1, id = n} into a READ_LATENCY-deep shift register; writes and non-issue cycles SHALL push valid = 0.
REQ-028 When the register output is valid, the arbiter SHALL assert m<id>_rvalid and drive m_rdata = s_rdata; reads return in issue order, exactly READ_LATENCY cycles after ack.
REQ-029 The arbiter SHALL NOT assert both rvalids in the same cycle, nor both acks in the same cycle.
REQ-030 A grant switch SHALL cost at most one cycle with no issue; back-to-back issues within a grant SHALL sustain 1 per cycle when s_ready = 1.
REQ-031 While s_ready = 0, the grant SHALL hold and no ack SHALL pulse; the counter SHALL not advance.

Reset
REQ-032 While reset = 1 at a clock edge: state = IDLE, last_grant = 1 (port 0 wins first tie), counter = 0, and the read shift register is cleared.
REQ-033 After reset: s_req = 0, m0_ack = m1_ack = 0, m0_rvalid = m1_rvalid = 0; m_rdata mirrors s_rdata and carries no meaning.
REQ-034 Reset mid-operation SHALL discard in-flight reads, so no rvalid is asserted for reads issued before reset.

Verification
REQ-035 Only m0 requests a read of addr 0x00010, s_ready = 1: m0_ack at cycle t; m0_rvalid at t+2 with m_rdata = SRAM[0x00010]; m1 outputs stay 0.
REQ-036 m0 and m1 both request continuously after reset, MAX_BURST = 8: m0 gets 8 acks, then at most 1 idle cycle, then m1 gets 8 acks, and the pattern alternates.
REQ-037 m0 writes 0xA5A5 to 0x00003, then m1 reads 0x00003: m1_rvalid with m_rdata = 0xA5A5 exactly READ_LATENCY cycles after m1_ack.
REQ-038 s_ready held 0 for 5 cycles with m1 requesting: no ack, s_req = 1, s_addr stable; first ack in the cycle s_ready returns to 1.
REQ-039 Interleaved reads m0, m1, m0: rvalids arrive in the order m0, m1, m0, each with the matching data and no overlap.
REQ-040 Reset asserted 1 cycle after a read ack: no rvalid is asserted afterwards; state returns to IDLE and s_req = 0.
